// File: rtl/axi_write_master_pkg.sv
// Shared types and AXI constants for the store-side AXI4 write master.
package gDefine;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] Word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_BURST,
    ST_RESP,
    ST_DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_write_master.sv
// AXI4 write master: turns one level-style store request into a single INCR burst,
// passing beat data straight through from upstream to the W channel.
module axi_write_master
  import gDefine::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                initWrite,
  input  logic [ADDR_W-1:0]   writeAddress,
  input  logic [7:0]          writeLen,
  input  logic                wDataValid,
  input  logic [DATA_W-1:0]   wData,
  input  logic [DATA_W/8-1:0] mask,
  output logic                wDataNext,
  output logic                wDone,
  output logic                wErr,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  state_e            state_q, state_d;
  logic              init_prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              aw_done_q, aw_done_d;
  logic              err_q, err_d;
  logic              aw_hs, w_hs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      init_prev_q <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      aw_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_prev_q <= initWrite;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      aw_done_q   <= aw_done_d;
      err_q       <= err_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q - 8'd1;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = wData;
  assign m_axi_wstrb   = mask;
  assign wDataNext     = m_axi_wvalid & m_axi_wready;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    aw_done_d     = aw_done_q;
    err_d         = err_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    wDone         = 1'b0;
    wErr          = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (initWrite && !init_prev_q) state_d = ST_ARM;
      end
      // Upstream address/length only become valid one cycle after the request rises.
      ST_ARM: begin
        addr_d     = writeAddress;
        len_d      = writeLen;
        beat_cnt_d = '0;
        aw_done_d  = 1'b0;
        err_d      = 1'b0;
        state_d    = (writeLen == 8'd0) ? ST_DONE : ST_BURST;
      end
      ST_BURST: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = wDataValid && (beat_cnt_q < len_q);
        m_axi_wlast   = (beat_cnt_q == len_q - 8'd1);
        aw_hs         = m_axi_awvalid && m_axi_awready;
        w_hs          = m_axi_wvalid && m_axi_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) beat_cnt_d = beat_cnt_q + 8'd1;
        // AW and the final W beat may finish in either order or together.
        if ((aw_done_q || aw_hs) && ((beat_cnt_q == len_q) || (w_hs && m_axi_wlast)))
          state_d = ST_RESP;
      end
      ST_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          err_d   = (m_axi_bresp != AXI_RESP_OKAY);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        wDone   = 1'b1;
        wErr    = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
